exit_status_ctrl: RTL and testbench

EXIT_STATUS_CTRL -- requirements
Module: exit_status_ctrl

---
 rtl/exit_status_ctrl.sv | 133 +++++++++++++
 tb/tb_exit_status_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/exit_status_ctrl.sv
// Exit-status collector: round-robin accepts one 2-bit code per agent per run and reports the worst.
// Optional watchdog enabled by defining EXIT_STATUS_TIMEOUT_EN.
module exit_status_ctrl #(
  parameter int          NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [2*NUM_REQ-1:0]   req_status_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     reported_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [1:0]             status_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_chk
    $error("exit_status_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] reported, reported_nxt, grant;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [1:0]         acc, acc_nxt, code_sel;
  logic               complete;
`ifdef EXIT_STATUS_TIMEOUT_EN
  logic [31:0]        cnt, cnt_nxt;
`endif

  // Code 10 is folded into ERROR so the remaining codes are ordered by bit-inclusion.
  function automatic logic [1:0] map_code(input logic [1:0] c);
    return (c == 2'b10) ? 2'b11 : c;
  endfunction

  function automatic logic [1:0] merge_code(input logic [1:0] a, input logic [1:0] b);
    return a | b;
  endfunction

  // Grant the eligible agent with the smallest circular distance from the pointer.
  always_comb begin
    int best_d;
    int d;
    grant    = '0;
    code_sel = 2'b00;
    ptr_nxt  = ptr;
    best_d   = NUM_REQ;
    d        = 0;
    if (state == S_COLLECT) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid_i[k] && !reported[k]) begin
          d = (k >= int'(ptr)) ? (k - int'(ptr)) : (k + NUM_REQ - int'(ptr));
          if (d < best_d) begin
            best_d   = d;
            grant    = '0;
            grant[k] = 1'b1;
            code_sel = map_code(req_status_i[2*k +: 2]);
            ptr_nxt  = PTR_W'((k + 1) % NUM_REQ);
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    reported_nxt = reported;
    acc_nxt      = acc;
    complete     = 1'b0;
`ifdef EXIT_STATUS_TIMEOUT_EN
    cnt_nxt      = cnt;
`endif
    case (state)
      S_COLLECT: begin
        if (|grant) begin
          reported_nxt = reported | grant;
          acc_nxt      = merge_code(acc, code_sel);
          complete     = (code_sel == 2'b11) || (&(reported | grant));
        end
`ifdef EXIT_STATUS_TIMEOUT_EN
        cnt_nxt = cnt + 32'd1;
        if (!complete && (cnt_nxt == 32'(TIMEOUT_CYCLES - 1))) begin
          acc_nxt   = 2'b11;
          state_nxt = S_DONE;
        end
`endif
        if (complete) state_nxt = S_DONE;
      end
      default: begin
        if (start_i) begin
          state_nxt    = S_COLLECT;
          reported_nxt = '0;
          acc_nxt      = 2'b00;
`ifdef EXIT_STATUS_TIMEOUT_EN
          cnt_nxt      = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      reported <= '0;
      ptr      <= '0;
      acc      <= 2'b00;
`ifdef EXIT_STATUS_TIMEOUT_EN
      cnt      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      reported <= reported_nxt;
      ptr      <= ptr_nxt;
      acc      <= acc_nxt;
`ifdef EXIT_STATUS_TIMEOUT_EN
      cnt      <= cnt_nxt;
`endif
    end
  end

  assign req_ready_o = grant;
  assign reported_o  = reported;
  assign busy_o      = (state == S_COLLECT);
  assign done_o      = (state == S_DONE);
  assign status_o    = (state == S_DONE) ? acc : 2'b11;

endmodule

// File: tb/tb_exit_status_ctrl.sv
// Randomized bench for exit_status_ctrl against a cycle-level reference model of the collection rules.
module tb_exit_status_ctrl;
  localparam int          N   = 4;
  localparam int unsigned TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [2*N-1:0] req_status = '0;
  logic [N-1:0]   req_ready, reported;
  logic           busy, done;
  logic [1:0]     status;

  int n_vec = 0;
  int n_err = 0;

  // reference model: phase 0 idle, 1 collecting, 2 finished
  int       m_phase = 0;
  bit [N-1:0] m_rep = '0;
  int       m_ptr = 0;
  int       m_rank = 0;
  int       m_cnt = 0;

  exit_status_ctrl #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .req_valid_i(req_valid),
    .req_status_i(req_status), .req_ready_o(req_ready), .reported_o(reported),
    .busy_o(busy), .done_o(done), .status_o(status)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_rank(input logic [1:0] c);
    if (c == 2'b00) return 0;
    if (c == 2'b01) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] rank_code(input int r);
    if (r == 0) return 2'b00;
    if (r == 1) return 2'b01;
    return 2'b11;
  endfunction

  function automatic bit agent_valid(input int k);
    return ((req_valid >> k) & 1) != 0;
  endfunction

  function automatic int model_grant();
    if (m_phase != 1) return -1;
    for (int d = 0; d < N; d++) begin
      int k;
      k = (m_ptr + d) % N;
      if (agent_valid(k) && !m_rep[k]) return k;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    int g;
    logic [N-1:0] exp_rdy;
    g = model_grant();
    exp_rdy = (g < 0) ? '0 : N'(1) << g;
    check_eq("ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("reported", 32'(reported), 32'(m_rep));
    check_eq("busy", 32'(busy), 32'(m_phase == 1));
    check_eq("done", 32'(done), 32'(m_phase == 2));
    check_eq("status", 32'(status), 32'((m_phase == 2) ? rank_code(m_rank) : 2'b11));
  endtask

  task automatic model_step();
    int g;
    bit fin;
    logic [1:0] c;
    g = model_grant();
    if (m_phase != 1) begin
      if (start) begin
        m_phase = 1; m_rep = '0; m_rank = 0; m_cnt = 0;
      end
    end else begin
      fin = 0;
      if (g >= 0) begin
        c = 2'(req_status >> (2 * g));
        m_rep = m_rep | (N'(1) << g);
        m_ptr = (g + 1) % N;
        if (code_rank(c) > m_rank) m_rank = code_rank(c);
        if (code_rank(c) == 2 || m_rep == {N{1'b1}}) fin = 1;
      end
`ifdef EXIT_STATUS_TIMEOUT_EN
      m_cnt++;
      if (!fin && m_cnt == int'(TMO) - 1) begin
        fin = 1; m_rank = 2;
      end
`endif
      if (fin) m_phase = 2;
    end
  endtask

  task automatic cycle(input bit s, input logic [N-1:0] v, input logic [2*N-1:0] st);
    @(negedge clk);
    start = s; req_valid = v; req_status = st;
    #1 check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; req_valid = '0;
    #1;
    m_phase = 0; m_rep = '0; m_ptr = 0; m_cnt = 0; m_rank = 0;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_reported", 32'(reported), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_status", 32'(status), 32'h3);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // all four agents ready at once with SUCCESS
    cycle(1, 4'hF, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 4'hF, 8'h00);
    #1 check_eq("all_ok_done", 32'(done), 32'h1);
    check_eq("all_ok_status", 32'(status), 32'h0);

    // agent 2 FAIL, others SUCCESS, out-of-order arrival
    cycle(1, 4'h0, 8'h00);
    cycle(0, 4'b1000, 8'b00_01_00_00);
    cycle(0, 4'b0100, 8'b00_01_00_00);
    cycle(0, 4'b0001, 8'b00_01_00_00);
    cycle(0, 4'b0010, 8'b00_01_00_00);
    #1 check_eq("fail_done", 32'(done), 32'h1);
    check_eq("fail_status", 32'(status), 32'h1);

    // agent 1 ERROR ends the run early
    cycle(1, 4'h0, 8'h00);
    cycle(0, 4'b0010, 8'b00_00_11_00);
    #1 check_eq("err_done", 32'(done), 32'h1);
    check_eq("err_status", 32'(status), 32'h3);
    check_eq("err_reported", 32'(reported), 32'b0010);

    // reset after two transfers, then a fresh run
    cycle(1, 4'h0, 8'h00);
    cycle(0, 4'b0011, 8'h00);
    cycle(0, 4'b0011, 8'h00);
    do_reset();
    cycle(1, 4'hF, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 4'hF, 8'h00);

    // agent 3 holds valid across a restart
    cycle(1, 4'h0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(0, 4'b1000 | (4'b1 << i), 8'h00);
    cycle(0, 4'b1000, 8'h00);
    cycle(1, 4'b1000, 8'h00);
    cycle(0, 4'b1000, 8'h00);
    cycle(0, 4'b1000, 8'h00);

`ifdef EXIT_STATUS_TIMEOUT_EN
    // watchdog: only agent 0 reports
    cycle(1, 4'h0, 8'h00);
    cycle(0, 4'b0001, 8'h00);
    for (int i = 2; i <= 14; i++) cycle(0, 4'h0, 8'h00);
    #1 check_eq("tmo_early", 32'(done), 32'h0);
    cycle(0, 4'h0, 8'h00);
    #1 check_eq("tmo_done", 32'(done), 32'h1);
    check_eq("tmo_status", 32'(status), 32'h3);
    // completion on the timeout cycle wins
    cycle(1, 4'h0, 8'h00);
    cycle(0, 4'b0001, 8'h00);
    cycle(0, 4'b0010, 8'h00);
    cycle(0, 4'b0100, 8'h00);
    for (int i = 4; i <= 14; i++) cycle(0, 4'h0, 8'h00);
    cycle(0, 4'b1000, 8'b01_00_00_00);
    #1 check_eq("tmo_tie_done", 32'(done), 32'h1);
    check_eq("tmo_tie_status", 32'(status), 32'h1);
`endif

    // randomized traffic with occasional restarts and resets
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0]   v;
      logic [2*N-1:0] st;
      v  = N'($urandom & $urandom);
      st = (2*N)'($urandom);
      if (($urandom % 4) != 0) st = st & {N{2'b01}};
      if (($urandom % 250) == 0) do_reset();
      else cycle(($urandom % 6) == 0, v, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
